// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package riscv_ctrl_pkg;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWB    = 4'd4;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;
  localparam logic [3:0] ST_EXECR    = 4'd6;
  localparam logic [3:0] ST_EXECI    = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;
  localparam logic [3:0] ST_TRAP     = 4'd11;

  typedef enum logic [3:0] {
    FETCH    = ST_FETCH,
    DECODE   = ST_DECODE,
    MEMADR   = ST_MEMADR,
    MEMREAD  = ST_MEMREAD,
    MEMWB    = ST_MEMWB,
    MEMWRITE = ST_MEMWRITE,
    EXECR    = ST_EXECR,
    EXECI    = ST_EXECI,
    ALUWB    = ST_ALUWB,
    BEQ      = ST_BEQ,
    JAL      = ST_JAL,
    TRAP     = ST_TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an ALU opcode.
// Purely combinational.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, which reuses Instr[30] as immediate
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle RV32I datapath (lw, sw, R, I, beq, jal);
// unknown opcodes park in TRAP until reset. Write enables are gated by reset.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       pc_update, branch, ir_wr, reg_wr, mem_wr;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_wr    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    alu_op    = ALUOP_ADD;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        ir_wr     = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      // branch target is computed here so BEQ can use the ALU for the compare
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_wr    = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
      end
      EXECR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_FUNCT;
      end
      EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_wr = 1'b1;
      BEQ: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_WD;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

  // reset may land while in FETCH, whose enables must not reach the datapath
  assign PCWrite  = rst & (pc_update | (branch & Zero));
  assign IRWrite  = rst & ir_wr;
  assign RegWrite = rst & reg_wr;
  assign MemWrite = rst & mem_wr;
  assign state    = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: each instruction's cycle sequence and per-cycle
// control outputs are predicted from the instruction semantics.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw;
    logic [1:0] res, srca, srcb;
    logic       regw;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       ill;
  } obs_t;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t observed();
    return {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            RegWrite, ImmSrc, ALUControl, illegal};
  endfunction

  // ALU operation an R/I instruction performs, by mnemonic
  function automatic logic [2:0] arith_op(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t expect_for(logic [3:0] st, logic [6:0] o, logic [2:0] f3,
                                      logic f7, logic z);
    obs_t e;
    e = '0;
    e.st = st;
    case (o)
      OP_SW:   e.imm = 2'b01;
      OP_BEQ:  e.imm = 2'b10;
      OP_JAL:  e.imm = 2'b11;
      default: e.imm = 2'b00;
    endcase
    case (st)
      ST_FETCH:    begin e.irw = 1; e.srcb = 2'b10; e.res = 2'b10; e.pcw = 1; end
      ST_DECODE:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      ST_MEMADR:   begin e.srca = 2'b10; e.srcb = 2'b01; end
      ST_MEMREAD:  e.adr = 1;
      ST_MEMWB:    begin e.res = 2'b01; e.regw = 1; end
      ST_MEMWRITE: begin e.adr = 1; e.memw = 1; end
      ST_EXECR:    begin e.srca = 2'b10; e.srcb = 2'b00; e.aluc = arith_op(o, f3, f7); end
      ST_EXECI:    begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = arith_op(o, f3, f7); end
      ST_ALUWB:    e.regw = 1;
      ST_BEQ:      begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; end
      ST_JAL:      begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      ST_TRAP:     e.ill = 1;
      default:     ;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH, checking up to 'limit' cycles of it.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic zb, input int limit);
    logic [3:0] seq[$];
    obs_t got, exp_v;
    op = o; funct3 = f3; funct7b5 = f7;
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (o)
      OP_LW:  begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMREAD); seq.push_back(ST_MEMWB); end
      OP_SW:  begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWRITE); end
      OP_R:   begin seq.push_back(ST_EXECR); seq.push_back(ST_ALUWB); end
      OP_I:   begin seq.push_back(ST_EXECI); seq.push_back(ST_ALUWB); end
      OP_BEQ: seq.push_back(ST_BEQ);
      OP_JAL: begin seq.push_back(ST_JAL); seq.push_back(ST_ALUWB); end
      default: repeat (10) seq.push_back(ST_TRAP);
    endcase
    for (int i = 0; i < seq.size() && i < limit; i++) begin
      @(negedge clk);
      Zero = (seq[i] == ST_BEQ) ? zb : 1'($urandom);
      #1;
      got   = observed();
      exp_v = expect_for(seq[i], o, f3, f7, Zero);
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h required %h", name, i, got, exp_v);
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t exp_v;
    rst = 1'b0; op = 7'b0110011; funct3 = 3'b110; funct7b5 = 1'b0; Zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      exp_v = expect_for(ST_FETCH, op, funct3, funct7b5, Zero);
      exp_v.pcw = 1'b0;
      exp_v.irw = 1'b0;
      n_cmp++;
      if (observed() !== exp_v) begin
        n_err++;
        $display("FAIL reset_hold %0d: got %h required %h", i, observed(), exp_v);
      end
    end
    release_reset();
  endtask

  task automatic test_lw();
    run_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0, 99);
  endtask

  task automatic test_sw();
    run_instr("sw", OP_SW, 3'b010, 1'b1, 1'b1, 99);
  endtask

  task automatic test_alu();
    run_instr("or", OP_R, 3'b110, 1'b0, 1'b0, 99);
    run_instr("sub", OP_R, 3'b000, 1'b1, 1'b0, 99);
    run_instr("addi", OP_I, 3'b000, 1'b1, 1'b0, 99);
    run_instr("slti", OP_I, 3'b010, 1'b0, 1'b0, 99);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", OP_BEQ, 3'b000, 1'b0, 1'b1, 99);
    run_instr("beq_not_taken", OP_BEQ, 3'b000, 1'b0, 1'b0, 99);
  endtask

  task automatic test_jal();
    run_instr("jal", OP_JAL, 3'b101, 1'b1, 1'b0, 99);
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    for (int n = 0; n < 40; n++)
      run_instr("random", ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom),
                1'($urandom), 99);
  endtask

  // Reset during MEMWB must kill the register write without waiting for a clock
  task automatic test_abort();
    run_instr("lw_abort", OP_LW, 3'b010, 1'b0, 1'b0, 5);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_FETCH || RegWrite !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      n_err++;
      $display("FAIL abort: got state=%0d RegWrite=%b PCWrite=%b IRWrite=%b required state=%0d enables=0",
               state, RegWrite, PCWrite, IRWrite, ST_FETCH);
    end
    release_reset();
  endtask

  task automatic test_trap();
    run_instr("trap", 7'b0000000, 3'($urandom), 1'($urandom), 1'b1, 99);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_FETCH || illegal !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      n_err++;
      $display("FAIL trap_reset: got state=%0d illegal=%b PCWrite=%b IRWrite=%b required state=%0d 0 0 0",
               state, illegal, PCWrite, IRWrite, ST_FETCH);
    end
    release_reset();
    run_instr("after_trap", OP_I, 3'b111, 1'b0, 1'b0, 99);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_beq();
    test_jal();
    test_back_to_back();
    test_abort();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
